// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types: memory access size and data-memory responder states
package cpu_types;

    typedef enum logic [1:0] {
        MEM_BYTE     = 2'd0,
        MEM_HALFWORD = 2'd1,
        MEM_WORD     = 2'd2
    } memory_mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_responder_state_t;

    localparam int LAT_CNT_W = 4;

    function automatic logic is_misaligned(input memory_mask_t mask, input logic [1:0] addr_lo);
        return ((mask == MEM_HALFWORD) && addr_lo[0]) ||
               ((mask == MEM_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_lane_formatter.sv
// rtl/memory_lane_formatter.sv - little-endian lane steering, byte enables and load extension
module memory_lane_formatter
    import cpu_types::*;
(
    input  logic [1:0]   addr_lo,
    input  memory_mask_t mask,
    input  logic         sign_ext,
    input  logic [31:0]  wdata,
    input  logic [31:0]  rword,
    output logic [3:0]   byte_en,
    output logic [31:0]  wdata_lane,
    output logic [31:0]  rdata,
    output logic         misaligned
);

    logic [31:0] rshift;

    always_comb begin
        misaligned = is_misaligned(mask, addr_lo);
        rshift     = rword >> {addr_lo, 3'b000};
        wdata_lane = wdata << {addr_lo, 3'b000};
        byte_en    = 4'b0000;
        rdata      = 32'h0;
        case (mask)
            MEM_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                rdata   = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
            end
            MEM_HALFWORD: begin
                byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                rdata   = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
            end
            MEM_WORD: begin
                byte_en = 4'b1111;
                rdata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
                rdata   = 32'h0;
            end
        endcase
        // A misaligned access neither writes nor returns data.
        if (misaligned) begin
            byte_en = 4'b0000;
            rdata   = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency single-outstanding data memory with load/store formatting
module data_memory_responder
    import cpu_types::*;
#(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         req_we,
    input  memory_mask_t req_mask,
    input  logic         req_sign_ext,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [31:0]  resp_rdata,
    output logic         resp_error
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    mem_responder_state_t   state_q;
    logic [LAT_CNT_W-1:0]   cnt_q;
    logic [IDX_W+1:0]       addr_q;
    logic                   we_q;
    memory_mask_t           mask_q;
    logic                   sext_q;
    logic [31:0]            resp_rdata_q;
    logic                   resp_error_q;
    logic [31:0]            mem_q [WORDS];

    logic                   idle;
    logic                   accept;
    logic [IDX_W+1:0]       f_addr;
    memory_mask_t           f_mask;
    logic                   f_sext;
    logic                   f_we;
    logic [31:0]            rword;
    logic [3:0]             fmt_be;
    logic [31:0]            fmt_wlane;
    logic [31:0]            fmt_rdata;
    logic                   fmt_mis;
    logic [31:0]            load_result;
    logic                   unused_addr_hi;

    assign idle           = (state_q == IDLE);
    assign accept         = req_valid && idle;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    // The formatter sees the live request while idle (store commit, LATENCY==1 load)
    // and the latched request otherwise.
    assign f_addr = idle ? req_addr[IDX_W+1:0] : addr_q;
    assign f_mask = idle ? req_mask : mask_q;
    assign f_sext = idle ? req_sign_ext : sext_q;
    assign f_we   = idle ? req_we : we_q;
    assign rword  = mem_q[f_addr[IDX_W+1:2]];

    memory_lane_formatter u_fmt (
        .addr_lo    (f_addr[1:0]),
        .mask       (f_mask),
        .sign_ext   (f_sext),
        .wdata      (req_wdata),
        .rword      (rword),
        .byte_en    (fmt_be),
        .wdata_lane (fmt_wlane),
        .rdata      (fmt_rdata),
        .misaligned (fmt_mis)
    );

    assign load_result = f_we ? 32'h0 : fmt_rdata;

    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (fmt_be[b]) begin
                    mem_q[f_addr[IDX_W+1:2]][8*b +: 8] <= fmt_wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            mask_q       <= MEM_BYTE;
            sext_q       <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr[IDX_W+1:0];
                        we_q   <= req_we;
                        mask_q <= req_mask;
                        sext_q <= req_sign_ext;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_rdata_q <= load_result;
                            resp_error_q <= fmt_mis;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_CNT_W'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_rdata_q <= load_result;
                        resp_error_q <= fmt_mis;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_rdata_q <= 32'h0;
                        resp_error_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = idle;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule
